// File: rtl/i2c_eeprom_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : i2c_eeprom_slave_ctrl
// Description: I2C slave front end for the EEPROM block. Oversamples SCL/SDA
//              in the system clock domain, decodes device address and word
//              pointer, and sequences byte writes/reads to a local memory.
//              SDA is driven open-drain through sda_oe.
// Revision   : 1.0 - initial release
// ============================================================================
module i2c_eeprom_slave_ctrl #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam logic [3:0] c_ST_IDLE      = 4'd0;
  localparam logic [3:0] c_ST_DEV_ADDR  = 4'd1;
  localparam logic [3:0] c_ST_DEV_ACK   = 4'd2;
  localparam logic [3:0] c_ST_WORD_ADDR = 4'd3;
  localparam logic [3:0] c_ST_WORD_ACK  = 4'd4;
  localparam logic [3:0] c_ST_WR_DATA   = 4'd5;
  localparam logic [3:0] c_ST_WR_ACK    = 4'd6;
  localparam logic [3:0] c_ST_RD_DATA   = 4'd7;
  localparam logic [3:0] c_ST_RD_ACK    = 4'd8;
  localparam logic [3:0] c_ST_WAIT_STOP = 4'd9;

  logic [3:0]        r_state, w_next_state;
  logic [1:0]        r_scl_sync, r_sda_sync;
  logic              r_scl_prev, r_sda_prev;
  logic [7:0]        r_shift;
  logic [3:0]        r_bit_cnt;
  logic              r_rw, r_sda_oe, r_mem_we, r_mem_re, r_load;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;

  logic w_scl_s, w_sda_s, w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_last_bit;
  logic [7:0] w_byte;

  assign w_scl_s    = r_scl_sync[1];
  assign w_sda_s    = r_sda_sync[1];
  assign w_scl_rise = w_scl_s & ~r_scl_prev;
  assign w_scl_fall = ~w_scl_s & r_scl_prev;
  assign w_sda_rise = w_sda_s & ~r_sda_prev;
  assign w_sda_fall = ~w_sda_s & r_sda_prev;
  assign w_start    = w_sda_fall & w_scl_s & r_scl_prev;
  assign w_stop     = w_sda_rise & w_scl_s & r_scl_prev;
  // Byte as it will stand once the bit on the current SCL rise is shifted in
  assign w_byte     = {r_shift[6:0], w_sda_s};
  assign w_last_bit = w_scl_rise & (r_bit_cnt == 4'd7);

  // Pin conditioning: two-stage synchronizers plus a history stage; idle bus is high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_in};
      r_sda_sync <= {r_sda_sync[0], sda_in};
      r_scl_prev <= r_scl_sync[1];
      r_sda_prev <= r_sda_sync[1];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: STOP beats START beats bit activity
  always_comb begin
    w_next_state = r_state;
    if (w_stop) begin
      w_next_state = c_ST_IDLE;
    end else if (w_start) begin
      w_next_state = c_ST_DEV_ADDR;
    end else begin
      case (r_state)
        c_ST_DEV_ADDR:  if (w_last_bit)
                          w_next_state = (w_byte[7:1] == DEV_ADDR) ? c_ST_DEV_ACK : c_ST_IDLE;
        c_ST_DEV_ACK:   if (w_scl_fall && r_sda_oe)
                          w_next_state = r_rw ? c_ST_RD_DATA : c_ST_WORD_ADDR;
        c_ST_WORD_ADDR: if (w_last_bit) w_next_state = c_ST_WORD_ACK;
        c_ST_WORD_ACK:  if (w_scl_fall && r_sda_oe) w_next_state = c_ST_WR_DATA;
        c_ST_WR_DATA:   if (w_last_bit) w_next_state = c_ST_WR_ACK;
        c_ST_WR_ACK:    if (w_scl_fall && r_sda_oe) w_next_state = c_ST_WR_DATA;
        c_ST_RD_DATA:   if (w_scl_fall && (r_bit_cnt == 4'd8)) w_next_state = c_ST_RD_ACK;
        c_ST_RD_ACK:    if (w_scl_rise) w_next_state = w_sda_s ? c_ST_WAIT_STOP : c_ST_RD_DATA;
        default:        w_next_state = r_state;
      endcase
    end
  end

  // Datapath: shifter, bit counter, SDA drive, pointer and memory strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift     <= 8'd0;
      r_bit_cnt   <= 4'd0;
      r_rw        <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_load      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'd0;
    end else begin
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      // Read data arrives one clk after the strobe; capture it the clk after that
      r_load   <= r_mem_re;
      if (r_load)   r_shift    <= mem_rdata;
      // Pointer advances the clk after each write strobe
      if (r_mem_we) r_mem_addr <= r_mem_addr + ADDR_W'(1);
      if (w_stop || w_start) begin
        // Any partial byte is abandoned; pointer is deliberately kept
        r_sda_oe  <= 1'b0;
        r_bit_cnt <= 4'd0;
      end else begin
        case (r_state)
          c_ST_DEV_ADDR, c_ST_WORD_ADDR, c_ST_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= w_last_bit ? 4'd0 : r_bit_cnt + 4'd1;
            end
            if (w_last_bit) begin
              if (r_state == c_ST_DEV_ADDR)  r_rw       <= w_sda_s;
              if (r_state == c_ST_WORD_ADDR) r_mem_addr <= w_byte[ADDR_W-1:0];
              if (r_state == c_ST_WR_DATA) begin
                r_mem_wdata <= w_byte;
                r_mem_we    <= 1'b1;
              end
            end
          end
          c_ST_DEV_ACK, c_ST_WORD_ACK, c_ST_WR_ACK: begin
            // ACK is pulled on the first fall after the byte and released on the next
            if (w_scl_rise && r_sda_oe && r_rw && (r_state == c_ST_DEV_ACK))
              r_mem_re <= 1'b1;
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else if (r_rw && (r_state == c_ST_DEV_ACK)) begin
                // ACK-ending fall also presents the first read bit
                r_sda_oe  <= ~r_shift[7];
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= 4'd1;
              end else begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
              end
            end
          end
          c_ST_RD_DATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
              end else begin
                r_sda_oe  <= ~r_shift[7];
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          c_ST_RD_ACK: begin
            if (w_scl_rise && !w_sda_s) begin
              r_mem_addr <= r_mem_addr + ADDR_W'(1);
              r_mem_re   <= 1'b1;
            end
          end
          default: r_sda_oe <= 1'b0;
        endcase
      end
    end
  end

  // Output decode: busy from state, everything else straight from registers
  always_comb begin
    busy      = (r_state != c_ST_IDLE);
    sda_oe    = r_sda_oe;
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    mem_we    = r_mem_we;
    mem_re    = r_mem_re;
  end

endmodule
`default_nettype wire
